record_splitter: RTL and testbench
==================================

// Module: record_splitter
// PURPOSE
// - Inverse of the two-engine aggregator: takes the packed 256-bit record stream and de-interleaves it back to two engine ports.
// - A record is a 32-bit length word L (excludes itself) plus L payload bytes, padded to a 4-byte lane.
// - Records are packed contiguously across words; L==32'hFFFF_FFFF marks end of a tungsten block.
// - Records alternate engine1, engine2, engine1...; each is re-aligned to lane 0 and emitted as whole beats.
// PARAMETERS
// - DATA_WIDTH    256  bus width; must equal 8*LENGTH_WIDTH (LANES=8, lane k = bits [32k+31:32k])
// - LENGTH_WIDTH  32   length-word / lane width
// PORTS
// - clk          in   1    clock; all logic on posedge
// - reset        in   1    synchronous, active-low reset
// - data_in      in   256  packed record stream
// - valid_in     in   1    data_in valid
// - ready_in     out  1    splitter accepts data_in this cycle (transfer = valid_in && ready_in)
// - data_out_1   out  256  engine1 record beat, header at lane 0
// - valid_out_1  out  1    engine1 beat valid
// - last_out_1   out  1    final beat of the record
// - ready_out_1  in   1    engine1 accepts beat
// - data_out_2, valid_out_2, last_out_2, ready_out_2: same as engine1 ports, for engine2
// - eob          out  1    one-cycle pulse on end-of-block marker
// BEHAVIOUR
// - Reset (reset==0 at posedge): all outputs 0; cur word, off, rem cleared; eng=ENGINE1; state=IDLE.
// - Reset mid-record discards the partial record; no further beats of it are emitted.
// - Regs: cur[255:0], off[3:0] (next unread lane, 0..8), rem (lanes left in record), eng (1-bit).
// - rem = (L+7)>>2, computed 33-bit so no overflow; L=5 -> 3 lanes, L=0 -> 1 lane.
// - IDLE: ready_in=1; on transfer cur<=data_in, off<=0 -> HDR.
// - HDR: L = cur lane off.
//   - L==FFFF_FFFF: eob<=1 for one cycle, eng<=ENGINE1, rest of cur dropped, off<=0 -> IDLE.
//   - else load rem -> EMIT.
// - EMIT, rem<=8-off: beat = (cur>>(32*off)), lanes>=rem zeroed, last=1. off<=off+rem, then eng toggles.
//   - On handshake: off==8 -> IDLE, else -> HDR.
// - EMIT, rem>8-off, off==0: beat=cur, last=0, rem<=rem-8 -> FETCH after handshake.
// - EMIT, rem>8-off, off!=0 -> FETCH first.
//   - On transfer: beat = {data_in lanes[0..off-1] at out lanes[8-off..7], cur lanes[off..7] at out lanes[0..7-off]}.
//   - Then rem<=rem-8 and cur<=data_in; off unchanged; re-evaluate EMIT rules.
// - FETCH: ready_in=1 only here and in IDLE; otherwise ready_in=0.
// - Output handshake: valid_out_x asserts only for eng==x, never both.
//   - data/last held stable while valid && !ready; cleared to 0 the cycle after handshake.
// - Latency: word accepted at T -> HDR at T+1 -> valid_out asserted at T+2 (first beat of a record).
// - Bytes inside the final partial lane pass through unmodified; only whole unused lanes are zeroed.
// - off==8 after a header-only consumption always fetches a new word before reading the next header.
// - Header in lane 7 with rem>1 is legal: cross-word case above.
// TESTING
// - One word: lane0 L=4, lane2 L=8, lane5 FFFF_FFFF -> e1 beat lanes0-1=w[0:1], lanes2-7=0, last.
//   - e2 beat lanes0-2=w[2:4], last; eob pulse.
//   - Next word's record goes to e1.
// - Lane0 L=60 (rem=16) -> e1 two beats = w0, w1; last only on 2nd.
//   - Next header at w2 lane0 goes to e2.
// - Crossing: w0 lane6 L=20 (rem=6) -> e1 beat lanes0-1=w0[6:7], lanes2-5=w1[0:3], lanes6-7=0, last.
//   - Next header read from w1 lane4.
// - Backpressure: ready_out_1=0 for 5 cycles during beat -> valid_out_1=1, data stable, ready_in=0.
//   - Beat completes on first ready_out_1=1.
// - L=5 at lane0, lane3 L=0 -> e1 3 lanes (lanes 3-7 zero); e2 1 lane (header only), both last=1.
// - reset=0 mid 3-beat record after beat 1 -> next cycle all outputs 0.
//   - After reset, a new word's record goes to e1 and the old record is never resumed.

Source files
------------

// File: rtl/record_splitter.sv
// record_splitter: de-interleaves a packed length-prefixed record stream onto two engine ports,
// re-aligning every record to lane 0 and emitting it as whole beats.
module record_splitter #(
    parameter int DATA_WIDTH   = 256,
    parameter int LENGTH_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out_1,
    output logic                  valid_out_1,
    output logic                  last_out_1,
    input  logic                  ready_out_1,
    output logic [DATA_WIDTH-1:0] data_out_2,
    output logic                  valid_out_2,
    output logic                  last_out_2,
    input  logic                  ready_out_2,
    output logic                  eob
);
    localparam int DW    = DATA_WIDTH;
    localparam int LW    = LENGTH_WIDTH;
    localparam int LANES = DW / LW;
    localparam int OW    = $clog2(LANES + 1);

    typedef enum logic [2:0] {IDLE, HDR, EMIT, FETCH, XMIT} state_t;

    state_t          state, state_n;
    logic [DW-1:0]   cur, cur_n, xbeat, xbeat_n, sh, obeat;
    logic [2*DW-1:0] xw;
    logic [OW-1:0]   off, off_n, off_sum;
    logic [LW-1:0]   rem, rem_n, hdr_len;
    logic [LW:0]     hdr_sum;
    logic            eng, eng_n, xlast, xlast_n, eob_n;
    logic            fits, present, olast, oready, hs, xfer;

    function automatic logic [DW-1:0] trim(input logic [DW-1:0] b, input logic [LW-1:0] n);
        for (int k = 0; k < LANES; k++)
            if (LW'(k) >= n) b[k*LW +: LW] = '0;
        return b;
    endfunction

    assign sh      = cur >> (LW * off);
    assign xw      = {data_in, cur} >> (LW * off);
    assign hdr_len = sh[LW-1:0];
    assign hdr_sum = {1'b0, hdr_len} + (LW+1)'(7);
    assign fits    = rem <= LW'(LANES) - LW'(off);
    assign off_sum = off + rem[OW-1:0];
    assign xfer    = valid_in && ready_in;
    assign ready_in = reset && (state == IDLE || state == FETCH);
    // A beat is on the bus when the current word can feed it alone, or a cross-word beat is staged.
    assign present = (state == EMIT && (fits || off == '0)) || state == XMIT;
    assign obeat   = state == XMIT ? xbeat : trim(sh, rem);
    assign olast   = state == XMIT ? xlast : fits;
    assign oready  = eng ? ready_out_2 : ready_out_1;
    assign hs      = present && oready;

    assign valid_out_1 = present && !eng;
    assign valid_out_2 = present && eng;
    assign data_out_1  = valid_out_1 ? obeat : '0;
    assign data_out_2  = valid_out_2 ? obeat : '0;
    assign last_out_1  = valid_out_1 && olast;
    assign last_out_2  = valid_out_2 && olast;

    always_comb begin
        state_n = state;
        cur_n   = cur;
        off_n   = off;
        rem_n   = rem;
        eng_n   = eng;
        xbeat_n = xbeat;
        xlast_n = xlast;
        eob_n   = 1'b0;
        case (state)
            IDLE: if (xfer) begin
                cur_n   = data_in;
                off_n   = '0;
                state_n = HDR;
            end
            HDR: if (hdr_len == '1) begin
                eob_n   = 1'b1;
                eng_n   = 1'b0;
                off_n   = '0;
                state_n = IDLE;
            end else begin
                rem_n   = {1'b0, hdr_sum[LW:2]};
                state_n = EMIT;
            end
            EMIT: if (fits) begin
                if (hs) begin
                    off_n   = off_sum;
                    eng_n   = !eng;
                    state_n = off_sum == OW'(LANES) ? IDLE : HDR;
                end
            end else if (off == '0) begin
                if (hs) begin
                    rem_n   = rem - LW'(LANES);
                    state_n = FETCH;
                end
            end else begin
                state_n = FETCH;
            end
            FETCH: if (xfer) begin
                cur_n   = data_in;
                xbeat_n = trim(xw[DW-1:0], rem);
                xlast_n = rem <= LW'(LANES);
                state_n = off == '0 ? EMIT : XMIT;
            end
            XMIT: if (hs) begin
                if (xlast) begin
                    off_n   = off_sum - OW'(LANES);
                    eng_n   = !eng;
                    state_n = HDR;
                end else begin
                    rem_n   = rem - LW'(LANES);
                    state_n = EMIT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cur   <= '0;
            off   <= '0;
            rem   <= '0;
            eng   <= 1'b0;
            xbeat <= '0;
            xlast <= 1'b0;
            eob   <= 1'b0;
        end else begin
            state <= state_n;
            cur   <= cur_n;
            off   <= off_n;
            rem   <= rem_n;
            eng   <= eng_n;
            xbeat <= xbeat_n;
            xlast <= xlast_n;
            eob   <= eob_n;
        end
    end
endmodule

// File: tb/tb_record_splitter.sv
// tb_record_splitter: directed spec scenarios plus a randomized stream checked against
// a lane-level record parser.
module tb_record_splitter;
    logic         clk = 0, reset = 0, valid_in = 0, ready_in;
    logic [255:0] data_in = '0, data_out_1, data_out_2;
    logic         valid_out_1, last_out_1, ready_out_1 = 1, valid_out_2, last_out_2, ready_out_2 = 1, eob;

    int passed = 0, total = 0, eob_cnt = 0, both_cnt = 0;
    bit rand_rdy = 0;
    logic [255:0] tx[$], g1_d[$], g2_d[$], e1_d[$], e2_d[$];
    logic         g1_l[$], g2_l[$], e1_l[$], e2_l[$];
    logic [31:0]  ln[$];

    record_splitter dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
        .data_out_1(data_out_1), .valid_out_1(valid_out_1), .last_out_1(last_out_1), .ready_out_1(ready_out_1),
        .data_out_2(data_out_2), .valid_out_2(valid_out_2), .last_out_2(last_out_2), .ready_out_2(ready_out_2),
        .eob(eob)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (reset) begin
        if (valid_out_1 && ready_out_1) begin g1_d.push_back(data_out_1); g1_l.push_back(last_out_1); end
        if (valid_out_2 && ready_out_2) begin g2_d.push_back(data_out_2); g2_l.push_back(last_out_2); end
        if (valid_out_1 && valid_out_2) both_cnt++;
        if (eob) eob_cnt++;
    end

    function automatic logic [255:0] w8(input logic [31:0] l0, l1, l2, l3, l4, l5, l6, l7);
        return {l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    task automatic sync();
        @(posedge clk); #1;
        if (rand_rdy) begin
            ready_out_1 = $urandom_range(0, 3) != 0;
            ready_out_2 = $urandom_range(0, 3) != 0;
        end
    endtask

    task automatic clear();
        g1_d = {}; g1_l = {}; g2_d = {}; g2_l = {}; eob_cnt = 0;
    endtask

    task automatic send_words(input int gap);
        int i = 0;
        int guard = 0;
        while (i < tx.size() && guard < 5000) begin
            valid_in = $urandom_range(0, 99) >= gap;
            data_in  = tx[i];
            @(negedge clk);
            if (valid_in && ready_in) i++;
            sync();
            guard++;
        end
        valid_in = 0;
        if (i < tx.size()) begin
            total++;
            $display("FAIL send: accepted %0d of %0d words", i, tx.size());
        end
        repeat (60) sync();
    endtask

    // Walks the flat lane list record by record, independent of word boundaries.
    task automatic model();
        int pos = 0;
        int n;
        bit e = 0;
        logic [255:0] bt;
        e1_d = {}; e1_l = {}; e2_d = {}; e2_l = {};
        while (pos < ln.size()) begin
            if (ln[pos] == 32'hFFFF_FFFF) begin
                e = 0;
                pos = (pos / 8 + 1) * 8;
            end else begin
                n = (int'(ln[pos]) + 7) / 4;
                for (int b = 0; b < n; b += 8) begin
                    bt = '0;
                    for (int k = 0; k < 8; k++) if (b + k < n) bt[k*32 +: 32] = ln[pos+b+k];
                    if (!e) begin e1_d.push_back(bt); e1_l.push_back(b + 8 >= n); end
                    else    begin e2_d.push_back(bt); e2_l.push_back(b + 8 >= n); end
                end
                pos += n;
                e = !e;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (valid_out_1 !== 0 || valid_out_2 !== 0) $display("FAIL reset valid: %b%b want 00", valid_out_1, valid_out_2); else passed++;
        total++; if (data_out_1 !== '0 || data_out_2 !== '0) $display("FAIL reset data: %h %h want 0", data_out_1, data_out_2); else passed++;
        total++; if (last_out_1 !== 0 || last_out_2 !== 0 || eob !== 0) $display("FAIL reset last/eob: %b%b%b want 000", last_out_1, last_out_2, eob); else passed++;
        total++; if (ready_in !== 0) $display("FAIL reset ready_in: %b want 0", ready_in); else passed++;
        reset = 1;
        sync();
        @(negedge clk);
        total++; if (ready_in !== 1) $display("FAIL idle ready_in: %b want 1", ready_in); else passed++;
    endtask

    task automatic test_single_word();
        logic [31:0] a = $urandom, b = $urandom, c = $urandom;
        logic [255:0] exp1 = w8(4, a, 0, 0, 0, 0, 0, 0);
        clear();
        sync();
        valid_in = 1;
        data_in  = w8(4, a, 8, b, c, 32'hFFFF_FFFF, $urandom, $urandom);
        @(negedge clk);
        total++; if (ready_in !== 1) $display("FAIL single accept: ready_in %b want 1", ready_in); else passed++;
        sync();
        valid_in = 0;
        @(negedge clk);
        total++; if (valid_out_1 !== 0) $display("FAIL latency T+1: valid_out_1 %b want 0", valid_out_1); else passed++;
        @(negedge clk);
        total++; if (valid_out_1 !== 1 || data_out_1 !== exp1) $display("FAIL latency T+2: valid %b data %h want 1 %h", valid_out_1, data_out_1, exp1); else passed++;
        repeat (20) sync();
        tx = {w8(0, 32'hFFFF_FFFF, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom)};
        send_words(0);
        total++; if (g1_d.size() !== 2 || g2_d.size() !== 1) $display("FAIL single counts: e1 %0d e2 %0d want 2 1", g1_d.size(), g2_d.size()); else passed++;
        total++; if (g1_d[0] !== exp1 || g1_l[0] !== 1) $display("FAIL single e1: %h last %b want %h 1", g1_d[0], g1_l[0], exp1); else passed++;
        total++; if (g2_d[0] !== w8(8, b, c, 0, 0, 0, 0, 0) || g2_l[0] !== 1) $display("FAIL single e2: %h last %b", g2_d[0], g2_l[0]); else passed++;
        total++; if (g1_d[1] !== '0 || g1_l[1] !== 1) $display("FAIL next word to e1: %h last %b want 0 1", g1_d[1], g1_l[1]); else passed++;
        total++; if (eob_cnt !== 2) $display("FAIL single eob: %0d pulses want 2", eob_cnt); else passed++;
    endtask

    task automatic test_multi_beat();
        logic [255:0] w0 = w8(60, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        logic [255:0] w1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        logic [31:0]  q = $urandom;
        clear();
        tx = {w0, w1, w8(4, q, 32'hFFFF_FFFF, $urandom, $urandom, $urandom, $urandom, $urandom)};
        send_words(20);
        total++; if (g1_d.size() !== 2 || g2_d.size() !== 1) $display("FAIL multi counts: e1 %0d e2 %0d want 2 1", g1_d.size(), g2_d.size()); else passed++;
        total++; if (g1_d[0] !== w0 || g1_l[0] !== 0) $display("FAIL multi beat0: %h last %b want %h 0", g1_d[0], g1_l[0], w0); else passed++;
        total++; if (g1_d[1] !== w1 || g1_l[1] !== 1) $display("FAIL multi beat1: %h last %b want %h 1", g1_d[1], g1_l[1], w1); else passed++;
        total++; if (g2_d[0] !== w8(4, q, 0, 0, 0, 0, 0, 0) || g2_l[0] !== 1) $display("FAIL multi e2: %h last %b", g2_d[0], g2_l[0]); else passed++;
    endtask

    task automatic test_crossing();
        logic [31:0] a = $urandom, b = $urandom, c = $urandom, d = $urandom, e = $urandom;
        logic [31:0] f = $urandom, g = $urandom, h = $urandom, i = $urandom, j = $urandom;
        clear();
        tx = {w8(16, a, b, c, d, 0, 20, e), w8(f, g, h, i, 4, j, 32'hFFFF_FFFF, $urandom)};
        send_words(30);
        total++; if (g1_d.size() !== 2 || g2_d.size() !== 2) $display("FAIL cross counts: e1 %0d e2 %0d want 2 2", g1_d.size(), g2_d.size()); else passed++;
        total++; if (g1_d[0] !== w8(16, a, b, c, d, 0, 0, 0)) $display("FAIL cross first rec: %h", g1_d[0]); else passed++;
        total++; if (g1_d[1] !== w8(20, e, f, g, h, i, 0, 0) || g1_l[1] !== 1) $display("FAIL cross beat: %h last %b", g1_d[1], g1_l[1]); else passed++;
        total++; if (g2_d[1] !== w8(4, j, 0, 0, 0, 0, 0, 0) || g2_l[1] !== 1) $display("FAIL cross next header: %h last %b", g2_d[1], g2_l[1]); else passed++;
        total++; if (eob_cnt !== 1) $display("FAIL cross eob: %0d want 1", eob_cnt); else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] a = $urandom, b = $urandom;
        logic [255:0] exp = w8(8, a, b, 0, 0, 0, 0, 0);
        clear();
        ready_out_1 = 0;
        tx = {w8(8, a, b, 32'hFFFF_FFFF, $urandom, $urandom, $urandom, $urandom)};
        send_words(0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (valid_out_1 !== 1 || data_out_1 !== exp || ready_in !== 0)
                $display("FAIL stall cycle %0d: valid %b ready_in %b data %h want 1 0 %h", k, valid_out_1, ready_in, data_out_1, exp);
            else passed++;
            sync();
        end
        ready_out_1 = 1;
        sync();
        @(negedge clk);
        total++; if (valid_out_1 !== 0 || data_out_1 !== '0) $display("FAIL after handshake: valid %b data %h want 0 0", valid_out_1, data_out_1); else passed++;
        repeat (10) sync();
        total++; if (g1_d.size() !== 1 || g1_d[0] !== exp || g1_l[0] !== 1) $display("FAIL stall beat: n %0d data %h want 1 %h", g1_d.size(), g1_d[0], exp); else passed++;
    endtask

    task automatic test_short_records();
        logic [31:0] a = $urandom, b = $urandom;
        clear();
        tx = {w8(5, a, b, 0, 32'hFFFF_FFFF, $urandom, $urandom, $urandom)};
        send_words(0);
        total++; if (g1_d.size() !== 1 || g1_d[0] !== w8(5, a, b, 0, 0, 0, 0, 0) || g1_l[0] !== 1) $display("FAIL L=5 beat: n %0d data %h", g1_d.size(), g1_d[0]); else passed++;
        total++; if (g2_d.size() !== 1 || g2_d[0] !== '0 || g2_l[0] !== 1) $display("FAIL L=0 beat: n %0d data %h", g2_d.size(), g2_d[0]); else passed++;
    endtask

    task automatic test_reset_mid_record();
        logic [31:0] a = $urandom;
        logic [255:0] w0 = w8(80, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        clear();
        tx = {w0};
        send_words(0);
        total++; if (g1_d.size() !== 1 || g1_d[0] !== w0 || g1_l[0] !== 0) $display("FAIL pre-reset beat: n %0d data %h", g1_d.size(), g1_d[0]); else passed++;
        reset = 0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (valid_out_1 !== 0 || valid_out_2 !== 0 || data_out_1 !== '0 || last_out_1 !== 0 || ready_in !== 0 || eob !== 0)
            $display("FAIL mid reset outputs: v %b%b l %b r %b eob %b", valid_out_1, valid_out_2, last_out_1, ready_in, eob);
        else passed++;
        sync();
        reset = 1;
        clear();
        tx = {w8(4, a, 32'hFFFF_FFFF, $urandom, $urandom, $urandom, $urandom, $urandom)};
        send_words(0);
        total++; if (g1_d.size() !== 1 || g1_d[0] !== w8(4, a, 0, 0, 0, 0, 0, 0) || g2_d.size() !== 0) $display("FAIL post-reset: e1 n %0d data %h e2 n %0d", g1_d.size(), g1_d[0], g2_d.size()); else passed++;
    endtask

    task automatic test_random();
        int bad = 0;
        ln = {};
        for (int r = 0; r < 60; r++) begin
            if ($urandom_range(0, 7) == 0) begin
                ln.push_back(32'hFFFF_FFFF);
                while (ln.size() % 8 != 0) ln.push_back($urandom);
            end else begin
                int l = $urandom_range(0, 80);
                ln.push_back(32'(l));
                for (int p = 0; p < (l + 3) / 4; p++) ln.push_back($urandom);
            end
        end
        ln.push_back(32'hFFFF_FFFF);
        while (ln.size() % 8 != 0) ln.push_back($urandom);
        tx = {};
        for (int w = 0; w < ln.size() / 8; w++) begin
            logic [255:0] x;
            for (int k = 0; k < 8; k++) x[k*32 +: 32] = ln[w*8+k];
            tx.push_back(x);
        end
        model();
        clear();
        rand_rdy = 1;
        send_words(30);
        rand_rdy = 0;
        ready_out_1 = 1;
        ready_out_2 = 1;
        repeat (20) sync();
        total++; if (g1_d.size() !== e1_d.size() || g2_d.size() !== e2_d.size()) $display("FAIL random counts: e1 %0d/%0d e2 %0d/%0d", g1_d.size(), e1_d.size(), g2_d.size(), e2_d.size()); else passed++;
        for (int k = 0; k < e1_d.size() && k < g1_d.size(); k++)
            if (g1_d[k] !== e1_d[k] || g1_l[k] !== e1_l[k]) begin
                if (bad < 5) $display("FAIL random e1 beat %0d: %h last %b want %h %b", k, g1_d[k], g1_l[k], e1_d[k], e1_l[k]);
                bad++;
            end
        for (int k = 0; k < e2_d.size() && k < g2_d.size(); k++)
            if (g2_d[k] !== e2_d[k] || g2_l[k] !== e2_l[k]) begin
                if (bad < 5) $display("FAIL random e2 beat %0d: %h last %b want %h %b", k, g2_d[k], g2_l[k], e2_d[k], e2_l[k]);
                bad++;
            end
        total++; if (bad !== 0) $display("FAIL random beats: %0d wrong want 0", bad); else passed++;
        total++; if (both_cnt !== 0) $display("FAIL both valid: %0d cycles want 0", both_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_multi_beat();
        test_crossing();
        test_backpressure();
        test_short_records();
        test_reset_mid_record();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
